fsmc_read_port: RTL and testbench
=================================

# fsmc_read_port

FPGA-side responder for STM32 FSMC read cycles: the read half of the FSMC link whose write half loads the wheel speed commands. It synchronizes NE/NOE into the `clk` domain and snapshots the selected status register. It then drives the 16-bit data bus through a registered output enable for the duration of the read. This gives the MCU access to encoder speeds, the infrared ball sensor, and battery and capacitor voltages.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum `clk` cycles the bus is driven per read. Used only with `FSMC_RD_TIMEOUT_EN`.
- `VERSION_WORD`, default 16'h5A18: constant returned at address 0x1B.
- `clk`  in  1  system clock; all logic lives on this single clock.
- `Rst_n`  in  1  asynchronous active-low reset.
- `NE`  in  1  FSMC chip select, active low, asynchronous to `clk`.
- `NOE`  in  1  FSMC output enable, active low, asynchronous to `clk`.
- `Address`  in  8  FSMC address, stable for the whole access.
- `enc1`..`enc4`  in  32 each  signed encoder speeds.
- `battery`  in  16  battery ADC value.
- `cap_v`  in  16  kick capacitor ADC value.
- `infrared`  in  1  ball sensor.
- `data_out`  out  16  read data, sent to the top-level tristate.
- `data_oe`  out  1  high = FPGA drives the data bus.
- `rd_strobe`  out  1  one-cycle pulse when read data is latched.
- `rd_timeout`  out  1  sticky flag: a bus drive was aborted by timeout.

## Operation
- `NE` and `NOE` each pass through a two-flop synchronizer with reset value 1. `Address` is sampled only in LATCH.
- Address map:
  - 0x10/0x11: `enc1` low/high half. 0x12/0x13: `enc2`. 0x14/0x15: `enc3`. 0x16/0x17: `enc4`.
  - 0x18: `battery`. 0x19: `cap_v`.
  - 0x1A: {15'b0, `infrared`}.
  - 0x1B: `VERSION_WORD`.
  - All other addresses return 16'h0000.
- Coherency: reading an even (low-half) encoder address copies bits [31:16] of the same encoder into a per-encoder shadow. The following odd-address read returns the shadow, not the live value. A high-half read without a preceding low-half read returns the last shadow (reset value 0).
- States:
  - IDLE → LATCH when synced NE=0 and NOE=0.
  - LATCH (one cycle): register the mux output into `data_out`, update the shadow if applicable, set `data_oe`=1, pulse `rd_strobe`. Always → DRIVE.
  - DRIVE: hold `data_out` and `data_oe`. → IDLE when synced NOE=1 or NE=1; `data_oe` is cleared on that transition.
  - WAIT_REL (timeout build only): `data_oe`=0. → IDLE when synced NOE=1.
- `data_out` keeps its last value in IDLE. Only `data_oe` gates the bus.
- Write cycles (NOE high) never leave IDLE.

## Timing
- Reset values: `data_out`=0, `data_oe`=0, `rd_strobe`=0, `rd_timeout`=0, shadows=0, state IDLE.
- Reset is asynchronous: asserting it mid-DRIVE drops `data_oe` immediately, without waiting for a clock edge.
- Read latency: NOE falling edge → `data_out`/`data_oe` valid within 3 `clk` edges (2 sync + LATCH).
  - MCU requirement: FSMC DATAST ≥ 4 `clk` periods.
- Release latency: NOE rising edge → `data_oe`=0 within 3 `clk` edges.
  - MCU requirement: BUSTURN ≥ 4 `clk` periods before the next write.
- Back-to-back reads: each read needs NOE high for ≥2 synced cycles so that IDLE is re-entered.
- `rd_strobe` is high exactly one cycle per read.

## Configuration
- `FSMC_RD_TIMEOUT_EN` defined:
  - A cycle counter runs in DRIVE.
  - After `TIMEOUT_CYCLES` cycles in DRIVE: go to WAIT_REL, clear `data_oe`, set `rd_timeout` (cleared only by reset).
- `FSMC_RD_TIMEOUT_EN` undefined:
  - No counter and no WAIT_REL state.
  - DRIVE persists while NOE stays low.
  - `rd_timeout` is tied to 0.

## Structure
- Shared include `fsmc_defs.vh` holds:
  - address constants (`ADDR_ENC1_LO`..`ADDR_VERSION`);
  - state encodings;
  - synchronizer depth.
- The write-side block uses the same address constants.
- Sub-module `fsmc_sync2`: parameterized-reset two-flop synchronizer, instantiated once for NE and once for NOE.

## Test plan
- Reset: hold `Rst_n`=0 with NE=NOE=0 → `data_oe`=0, `data_out`=0, `rd_strobe`=0. Release reset → read proceeds normally.
- Battery read: `battery`=16'h0BB8, read at 0x18 → `data_oe`=1 and `data_out`=16'h0BB8 by the 3rd edge after NOE falls; one `rd_strobe` pulse; `data_oe`=0 within 3 edges after NOE rises.
- Coherent encoder read:
  - `enc1`=32'h0001FFFF; read 0x10 → 16'hFFFF.
  - Change `enc1` to 32'h00020000; read 0x11 → 16'h0001.
  - Read 0x10 again → 16'h0000.
- Unmapped and version: read 0x40 → 16'h0000. Read 0x1B → 16'h5A18. Write cycle (NOE high, NE low) → `data_oe` stays 0.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): hold NOE low 50 cycles → `data_oe` falls 8 cycles after entering DRIVE; `rd_timeout`=1; no new read until NOE goes high.
- Reset mid-read: assert `Rst_n`=0 during DRIVE → `data_oe`=0 with no clock edge; shadows cleared (read 0x11 → 16'h0000).

Source files
------------

// File: rtl/fsmc_read_port_pkg.sv
// Shared definitions for the FSMC link: register address map, read-port
// state encoding and synchronizer depth. The write-side block uses the same
// address constants.
package fsmc_read_port_pkg;

   // Depth of the NE/NOE synchronizers.
   localparam int SYNC_DEPTH = 2;

   // Register address map as seen by the MCU.
   localparam logic [7:0] ADDR_ENC1_LO = 8'h10;
   localparam logic [7:0] ADDR_ENC1_HI = 8'h11;
   localparam logic [7:0] ADDR_ENC2_LO = 8'h12;
   localparam logic [7:0] ADDR_ENC2_HI = 8'h13;
   localparam logic [7:0] ADDR_ENC3_LO = 8'h14;
   localparam logic [7:0] ADDR_ENC3_HI = 8'h15;
   localparam logic [7:0] ADDR_ENC4_LO = 8'h16;
   localparam logic [7:0] ADDR_ENC4_HI = 8'h17;
   localparam logic [7:0] ADDR_BATTERY = 8'h18;
   localparam logic [7:0] ADDR_CAP_V   = 8'h19;
   localparam logic [7:0] ADDR_IR      = 8'h1A;
   localparam logic [7:0] ADDR_VERSION = 8'h1B;

   // Read-port states. ST_WAIT_REL is only reachable in the timeout build.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LATCH    = 2'd1,
      ST_DRIVE    = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_t;

endpackage : fsmc_read_port_pkg

// File: rtl/fsmc_sync2.sv
// Multi-flop synchronizer for one asynchronous control line with a
// selectable reset value (FSMC strobes idle high, so they reset to 1).
module fsmc_sync2
   import fsmc_read_port_pkg::*;
#(
   parameter int   DEPTH   = SYNC_DEPTH,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {DEPTH{RST_VAL}};
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour.
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule : fsmc_sync2

// File: rtl/fsmc_read_port.sv
// FPGA-side responder for STM32 FSMC read cycles. Synchronizes NE/NOE,
// snapshots the addressed status register into data_out and drives the bus
// through a registered output enable while the MCU holds NOE low.
// Encoder reads are made coherent by shadowing the high half on a low-half read.
// Optional build macro: FSMC_RD_TIMEOUT_EN -- bounds the bus drive to
// TIMEOUT_CYCLES clocks and raises the sticky rd_timeout flag on expiry.
module fsmc_read_port
   import fsmc_read_port_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [15:0] VERSION_WORD   = 16'h5A18
) (
   input  logic        clk,
   input  logic        Rst_n,
   input  logic        NE,
   input  logic        NOE,
   input  logic [7:0]  Address,
   input  logic [31:0] enc1,
   input  logic [31:0] enc2,
   input  logic [31:0] enc3,
   input  logic [31:0] enc4,
   input  logic [15:0] battery,
   input  logic [15:0] cap_v,
   input  logic        infrared,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        rd_strobe,
   output logic        rd_timeout
);

   logic        ne_s;
   logic        noe_s;
   state_t      state;
   state_t      next_state;
   logic [15:0] mux_data;
   logic [15:0] shadow [4];
   logic        load;
   logic        oe_d;

   fsmc_sync2 #(.RST_VAL(1'b1)) u_sync_ne (
      .clk   (clk),
      .rst_n (Rst_n),
      .d     (NE),
      .q     (ne_s)
   );

   fsmc_sync2 #(.RST_VAL(1'b1)) u_sync_noe (
      .clk   (clk),
      .rst_n (Rst_n),
      .d     (NOE),
      .q     (noe_s)
   );

`ifdef FSMC_RD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] drive_cnt;
   logic             timeout_hit;

   assign timeout_hit = (drive_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count cycles spent in DRIVE; cleared whenever DRIVE is (re)entered or left.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         drive_cnt <= '0;
      end else if (state == ST_DRIVE && next_state == ST_DRIVE) begin
         drive_cnt <= drive_cnt + 1'b1;
      end else begin
         drive_cnt <= '0;
      end
   end

   // Sticky timeout flag, only cleared by reset.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rd_timeout <= 1'b0;
      end else if (state == ST_DRIVE && next_state == ST_WAIT_REL) begin
         rd_timeout <= 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign rd_timeout         = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a read starts on synced NE=NOE=0 and ends on release.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_state unassigned
      // (which would infer a latch).
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (!ne_s && !noe_s) next_state = ST_LATCH;
         end
         ST_LATCH: begin
            next_state = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (noe_s || ne_s) begin
               next_state = ST_IDLE;
            end
`ifdef FSMC_RD_TIMEOUT_EN
            else if (timeout_hit) begin
               next_state = ST_WAIT_REL;
            end
`endif
         end
`ifdef FSMC_RD_TIMEOUT_EN
         ST_WAIT_REL: begin
            if (noe_s) next_state = ST_IDLE;
         end
`endif
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode: registered outputs follow the state being entered, so
   // data_oe/rd_strobe/data_out are valid on the edge that enters LATCH.
   always_comb begin
      load = (next_state == ST_LATCH);
      oe_d = (next_state == ST_LATCH) || (next_state == ST_DRIVE);
   end

   // Read mux: live register values, shadows for the encoder high halves.
   always_comb begin
      mux_data = 16'h0000;
      case (Address)
         ADDR_ENC1_LO: mux_data = enc1[15:0];
         ADDR_ENC1_HI: mux_data = shadow[0];
         ADDR_ENC2_LO: mux_data = enc2[15:0];
         ADDR_ENC2_HI: mux_data = shadow[1];
         ADDR_ENC3_LO: mux_data = enc3[15:0];
         ADDR_ENC3_HI: mux_data = shadow[2];
         ADDR_ENC4_LO: mux_data = enc4[15:0];
         ADDR_ENC4_HI: mux_data = shadow[3];
         ADDR_BATTERY: mux_data = battery;
         ADDR_CAP_V:   mux_data = cap_v;
         ADDR_IR:      mux_data = {15'b0, infrared};
         ADDR_VERSION: mux_data = VERSION_WORD;
         default:      mux_data = 16'h0000;
      endcase
   end

   // Encoder shadows: a low-half read captures the matching high half.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         // NOTE: the shadows are a small register array (not RAM) and their
         // reset value is visible to software, so they are reset explicitly.
         for (int i = 0; i < 4; i++) shadow[i] <= 16'h0000;
      end else if (load) begin
         case (Address)
            ADDR_ENC1_LO: shadow[0] <= enc1[31:16];
            ADDR_ENC2_LO: shadow[1] <= enc2[31:16];
            ADDR_ENC3_LO: shadow[2] <= enc3[31:16];
            ADDR_ENC4_LO: shadow[3] <= enc4[31:16];
            default: ;
         endcase
      end
   end

   // Bus-side registers: snapshot data on LATCH, enable and strobe follow state.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         data_out  <= 16'h0000;
         data_oe   <= 1'b0;
         rd_strobe <= 1'b0;
      end else begin
         if (load) data_out <= mux_data;
         data_oe   <= oe_d;
         rd_strobe <= load;
      end
   end

endmodule : fsmc_read_port

// File: tb/tb_fsmc_read_port.sv
// Self-checking bench for fsmc_read_port: directed table of spec vectors,
// hand-written reset / write / long-hold / mid-read-reset sequences and
// randomized reads against a behavioural register-map model.
module tb_fsmc_read_port;

   logic        clk = 1'b0;
   logic        Rst_n;
   logic        NE;
   logic        NOE;
   logic [7:0]  Address;
   logic [31:0] enc [4];
   logic [15:0] battery;
   logic [15:0] cap_v;
   logic        infrared;
   logic [15:0] data_out;
   logic        data_oe;
   logic        rd_strobe;
   logic        rd_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: per-encoder shadow of the high half.
   logic [15:0] m_shadow [4];

   always #5 clk = ~clk;

   fsmc_read_port #(
      .TIMEOUT_CYCLES (8),
      .VERSION_WORD   (16'h5A18)
   ) dut (
      .clk        (clk),
      .Rst_n      (Rst_n),
      .NE         (NE),
      .NOE        (NOE),
      .Address    (Address),
      .enc1       (enc[0]),
      .enc2       (enc[1]),
      .enc3       (enc[2]),
      .enc4       (enc[3]),
      .battery    (battery),
      .cap_v      (cap_v),
      .infrared   (infrared),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .rd_strobe  (rd_strobe),
      .rd_timeout (rd_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Register-map model: what the MCU should read at address a right now.
   function automatic logic [15:0] model_read(input logic [7:0] a);
      int idx;
      if (a >= 8'h10 && a <= 8'h17) begin
         idx = (int'(a) - 16) / 2;
         if (a % 2 == 0) begin
            m_shadow[idx] = enc[idx][31:16];
            return enc[idx][15:0];
         end
         return m_shadow[idx];
      end
      case (a)
         8'h18:   return battery;
         8'h19:   return cap_v;
         8'h1A:   return {15'b0, infrared};
         8'h1B:   return 16'h5A18;
         default: return 16'h0000;
      endcase
   endfunction

   // One complete FSMC read: checks latency, data, hold, single strobe, release.
   task automatic read_cycle(input logic [7:0] a, input logic [15:0] exp, input string name);
      int strobes = 0;
      @(negedge clk);
      Address = a;
      NE      = 1'b0;
      NOE     = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         strobes += int'(rd_strobe);
      end
      check({name, "_oe"}, data_oe, 1'b1);
      check({name, "_data"}, data_out, exp);
      repeat (3) begin
         @(posedge clk); #1;
         strobes += int'(rd_strobe);
      end
      check({name, "_hold"}, {data_oe, data_out}, {1'b1, exp});
      @(negedge clk);
      NOE = 1'b1;
      NE  = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         strobes += int'(rd_strobe);
      end
      check({name, "_release"}, data_oe, 1'b0);
      check({name, "_strobes"}, strobes, 1);
      repeat (2) @(posedge clk);
   endtask

   typedef struct {
      string       name;
      logic [7:0]  addr;
      logic [31:0] enc1;
      logic [15:0] battery;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int strobes;
      int oe_cycles;
      logic [15:0] exp;
      logic [7:0]  a;

      vecs[0] = '{"battery",  8'h18, 32'h0000_0000, 16'h0BB8, 16'h0BB8};
      vecs[1] = '{"enc1_lo",  8'h10, 32'h0001_FFFF, 16'h0BB8, 16'hFFFF};
      vecs[2] = '{"enc1_hi",  8'h11, 32'h0002_0000, 16'h0BB8, 16'h0001};
      vecs[3] = '{"enc1_lo2", 8'h10, 32'h0002_0000, 16'h0BB8, 16'h0000};
      vecs[4] = '{"unmapped", 8'h40, 32'h0002_0000, 16'h0BB8, 16'h0000};
      vecs[5] = '{"version",  8'h1B, 32'h0002_0000, 16'h0BB8, 16'h5A18};

      for (int i = 0; i < 4; i++) begin
         enc[i]      = 32'h0;
         m_shadow[i] = 16'h0;
      end
      cap_v    = 16'h0123;
      infrared = 1'b0;

      // Reset held with a read request pending.
      Rst_n   = 1'b0;
      NE      = 1'b0;
      NOE     = 1'b0;
      Address = 8'h18;
      battery = 16'h0BB8;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {data_oe, rd_strobe, rd_timeout, data_out}, 19'h0);
      @(negedge clk);
      Rst_n   = 1'b1;
      strobes = 0;
      repeat (3) begin
         @(posedge clk); #1;
         strobes += int'(rd_strobe);
      end
      check("post_rst_read", {data_oe, data_out}, {1'b1, 16'h0BB8});
      check("post_rst_strobe", strobes, 1);
      @(negedge clk);
      NE  = 1'b1;
      NOE = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_release", data_oe, 1'b0);
      repeat (2) @(posedge clk);

      // Directed spec vectors.
      for (int i = 0; i < 6; i++) begin
         enc[0]  = vecs[i].enc1;
         battery = vecs[i].battery;
         void'(model_read(vecs[i].addr));
         read_cycle(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end

      // Write cycle: NE low, NOE high must never drive the bus.
      @(negedge clk);
      NE        = 1'b0;
      Address   = 8'h18;
      oe_cycles = 0;
      repeat (10) begin
         @(posedge clk); #1;
         oe_cycles += int'(data_oe | rd_strobe);
      end
      check("write_no_drive", oe_cycles, 0);
      @(negedge clk);
      NE = 1'b1;
      repeat (3) @(posedge clk);

      // Long hold of NOE low (timeout behaviour depends on the build).
      infrared = 1'b1;
      @(negedge clk);
      Address   = 8'h1A;
      NE        = 1'b0;
      NOE       = 1'b0;
      strobes   = 0;
      oe_cycles = 0;
      repeat (50) begin
         @(posedge clk); #1;
         strobes   += int'(rd_strobe);
         oe_cycles += int'(data_oe);
      end
      check("hold_strobes", strobes, 1);
      check("hold_data", data_out, 16'h0001);
`ifdef FSMC_RD_TIMEOUT_EN
      // Edge 3 enters LATCH, edge 4 DRIVE, enable drops on edge 12.
      check("timeout_oe_cycles", oe_cycles, 9);
      check("timeout_flag", rd_timeout, 1'b1);
`else
      check("persist_oe_cycles", oe_cycles, 48);
      check("no_timeout_flag", rd_timeout, 1'b0);
`endif
      @(negedge clk);
      NE  = 1'b1;
      NOE = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("hold_release", data_oe, 1'b0);
      repeat (2) @(posedge clk);

      // Randomized reads against the model.
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < 4; j++) enc[j] = $urandom;
         battery  = 16'($urandom);
         cap_v    = 16'($urandom);
         infrared = 1'($urandom);
         if ($urandom_range(0, 15) < 13) a = 8'(8'h10 + $urandom_range(0, 11));
         else                            a = 8'($urandom);
         exp = model_read(a);
         read_cycle(a, exp, $sformatf("rand%0d_a%02h", i, a));
      end
`ifdef FSMC_RD_TIMEOUT_EN
      check("timeout_sticky", rd_timeout, 1'b1);
`endif

      // Asynchronous reset in the middle of DRIVE.
      enc[0] = 32'hABCD_1234;
      @(negedge clk);
      Address = 8'h10;
      NE      = 1'b0;
      NOE     = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_pre", {data_oe, data_out}, {1'b1, 16'h1234});
      @(negedge clk);
      #1;
      Rst_n = 1'b0;
      NE    = 1'b1;
      NOE   = 1'b1;
      #1;
      check("midrst_async_oe", data_oe, 1'b0);
      check("midrst_async_data", {rd_timeout, data_out}, 17'h0);
      @(negedge clk);
      Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) m_shadow[i] = 16'h0;
      repeat (2) @(posedge clk);
      read_cycle(8'h11, model_read(8'h11), "midrst_shadow");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fsmc_read_port
